wb_arbiter: RTL

Writeback arbiter for the frisc core: merges results from the ALU and the memory (load) unit into the register file's single write port. It also keeps a 32-entry pending-write scoreboard that decode uses to detect RAW hazards. It sits between the execute/memory stages and the register file and drives the file's `en`/`rd`/`data` write inputs from a registered output stage.

---
 rtl/frisc_pkg.sv | 23 ++
 rtl/wb_arbiter_if.sv | 55 +++++
 rtl/wb_scoreboard.sv | 48 ++++
 rtl/wb_arbiter.sv | 99 +++++++++
 4 files changed

// File: rtl/frisc_pkg.sv
// ---------------------------------------------------------------------------
// frisc_pkg
// Shared definitions for the frisc core writeback path.
//   XLEN      : data width of a register-file write
//   NREG      : architectural register count
//   AW        : register index width (log2 of NREG)
//   reg_idx_t : register index type
//   wb_req_t  : one writeback request {rd, data}
// ---------------------------------------------------------------------------
package frisc_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef logic [AW-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t        rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_if
// Bundles every bus signal of the writeback arbiter.
//   alu_valid/alu_ready/alu_rd/alu_data : ALU result channel
//   mem_valid/mem_ready/mem_rd/mem_data : load result channel
//   claim_en/claim_rd                   : decode claims a destination register
//   rf_en/rf_rd/rf_data                 : registered register-file write port
//   busy                                : pending-write scoreboard
// Modports:
//   slave  : the arbiter (consumes results and claims, drives the write port)
//   master : the producers / decode / register file side
// ---------------------------------------------------------------------------
interface wb_arbiter_if;
    import frisc_pkg::*;

    logic            alu_valid;
    logic            alu_ready;
    reg_idx_t        alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            mem_valid;
    logic            mem_ready;
    reg_idx_t        mem_rd;
    logic [XLEN-1:0] mem_data;

    logic            claim_en;
    reg_idx_t        claim_rd;

    logic            rf_en;
    reg_idx_t        rf_rd;
    logic [XLEN-1:0] rf_data;

    logic [NREG-1:0] busy;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        input  claim_en, claim_rd,
        output rf_en, rf_rd, rf_data,
        output busy
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        output claim_en, claim_rd,
        input  rf_en, rf_rd, rf_data,
        input  busy
    );

endinterface

// File: rtl/wb_scoreboard.sv
// ---------------------------------------------------------------------------
// wb_scoreboard
// Pending-write scoreboard used by decode for RAW hazard detection.
//   clk      : core clock
//   reset_n  : asynchronous reset, active-low (clears every bit)
//   claim_en : decode issues an instruction writing claim_rd
//   claim_rd : register being claimed
//   clr_en   : register file commits a write this cycle
//   clr_rd   : register being committed
//   busy     : bit i high means a write to xi is still pending
// ---------------------------------------------------------------------------
module wb_scoreboard
    import frisc_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            claim_en,
    input  reg_idx_t        claim_rd,
    input  logic            clr_en,
    input  reg_idx_t        clr_rd,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Set has priority over clear: a claim arriving on the commit cycle
    // belongs to a younger instruction, so the register must stay busy.
    // x0 is never tracked because writes to it are discarded.
    always_comb begin
        busy_d = '0;
        for (int i = 1; i < NREG; i++) begin
            busy_d[i] = (claim_en && (claim_rd == reg_idx_t'(i))) ||
                        (busy_q[i] && !(clr_en && (clr_rd == reg_idx_t'(i))));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Writeback arbiter for the frisc core. Merges ALU and load results into the
// register file's single write port through a one-cycle registered output
// stage and keeps the pending-write scoreboard.
//   clk     : core clock, all state updates on the rising edge
//   reset_n : asynchronous reset, active-low
//   bus     : wb_arbiter_if.slave (result channels, claims, write port, busy)
// Configuration:
//   WB_RR_EN defined   : contended grants alternate between mem and ALU
//   WB_RR_EN undefined : fixed priority, mem always beats ALU
// ---------------------------------------------------------------------------
module wb_arbiter
    import frisc_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    wb_arbiter_if.slave bus
);

    wb_req_t         alu_req;
    wb_req_t         mem_req;
    wb_req_t         win_req;
    logic            alu_grant;
    logic            mem_grant;
    logic            alu_xfer;
    logic            mem_xfer;
    logic            rf_en_q;
    reg_idx_t        rf_rd_q;
    logic [XLEN-1:0] rf_data_q;

    assign alu_req = '{rd: bus.alu_rd, data: bus.alu_data};
    assign mem_req = '{rd: bus.mem_rd, data: bus.mem_data};

`ifdef WB_RR_EN
    // mem_first names the channel that wins the next contended cycle. It
    // flips only when both channels are valid, which is exactly when a
    // contended grant happens because the output stage never stalls.
    logic mem_first;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_first <= 1'b1;
        end else if (bus.alu_valid && bus.mem_valid) begin
            mem_first <= !mem_first;
        end
    end

    assign mem_grant = !bus.alu_valid || mem_first;
    assign alu_grant = !bus.mem_valid || !mem_first;
`else
    // Fixed priority: mem is always ready, the ALU only when mem is idle.
    assign mem_grant = 1'b1;
    assign alu_grant = !bus.mem_valid;
`endif

    // Each ready looks only at the other channel's valid, so a producer
    // can never form a combinational loop through its own handshake.
    assign bus.mem_ready = reset_n && mem_grant;
    assign bus.alu_ready = reset_n && alu_grant;

    assign mem_xfer = bus.mem_valid && bus.mem_ready;
    assign alu_xfer = bus.alu_valid && bus.alu_ready;
    assign win_req  = mem_xfer ? mem_req : alu_req;

    // Output stage: the register file takes a write every cycle, so the
    // stage never back-pressures. Writes to x0 complete the handshake but
    // leave the enable low; index and data hold when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_en_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
        end else if (mem_xfer || alu_xfer) begin
            rf_en_q   <= (win_req.rd != '0);
            rf_rd_q   <= win_req.rd;
            rf_data_q <= win_req.data;
        end else begin
            rf_en_q   <= 1'b0;
        end
    end

    assign bus.rf_en   = rf_en_q;
    assign bus.rf_rd   = rf_rd_q;
    assign bus.rf_data = rf_data_q;

    // The scoreboard clears from the registered write port so a busy bit
    // drops on the same edge the register file commits the value.
    wb_scoreboard u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .claim_en (bus.claim_en),
        .claim_rd (bus.claim_rd),
        .clr_en   (rf_en_q),
        .clr_rd   (rf_rd_q),
        .busy     (bus.busy)
    );

endmodule
